e203_exu_longp_wbsched: RTL

Long-pipe write-back scheduler between the long-pipeline execution units (LSU, MULDIV) and the regfile write-back arbiter. Only the result whose OITF tag equals the OITF retire pointer is accepted, so long-pipe results retire in program order. The accepted result is registered into a one-entry output stage. That stage drives either the long-pipe write-back port or the long-pipe exception port. The OITF entry is retired in the same cycle the result is accepted.

---
 rtl/e203_exu_longp_wbsched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/e203_exu_longp_wbsched.sv
// e203_exu_longp_wbsched
// Long-pipe write-back scheduler. Picks the long-pipe result (LSU or MULDIV)
// whose OITF tag equals the OITF retire pointer, so results retire in program
// order. The accepted result is registered into a one-entry output stage.
// That stage presents either a regfile write-back request or a long-pipe
// exception. The OITF entry is retired in the same cycle the result is
// accepted.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   lsu_wbck_i_*            LSU result handshake (valid/ready, data, tag, err)
//   mdv_wbck_i_*            MULDIV result handshake (valid/ready, data, tag)
//   oitf_empty/ret_*        OITF oldest-entry information
//   oitf_ret_ena            retire pulse for the oldest OITF entry
//   longp_wbck_o_*          registered write-back request to the arbiter
//   longp_excp_o_*          registered exception request to the commit unit
//   wb_stall_cnt            saturating count of back-pressured output cycles
module e203_exu_longp_wbsched #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int ITAG_W  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lsu_wbck_i_valid,
  output logic               lsu_wbck_i_ready,
  input  logic [XLEN-1:0]    lsu_wbck_i_wdat,
  input  logic [ITAG_W-1:0]  lsu_wbck_i_itag,
  input  logic               lsu_wbck_i_err,
  input  logic               mdv_wbck_i_valid,
  output logic               mdv_wbck_i_ready,
  input  logic [XLEN-1:0]    mdv_wbck_i_wdat,
  input  logic [ITAG_W-1:0]  mdv_wbck_i_itag,
  input  logic               oitf_empty,
  input  logic [ITAG_W-1:0]  oitf_ret_ptr,
  input  logic [RFIDX_W-1:0] oitf_ret_rdidx,
  input  logic               oitf_ret_rdwen,
  output logic               oitf_ret_ena,
  output logic               longp_wbck_o_valid,
  input  logic               longp_wbck_o_ready,
  output logic [XLEN-1:0]    longp_wbck_o_wdat,
  output logic [RFIDX_W-1:0] longp_wbck_o_rdidx,
  output logic               longp_excp_o_valid,
  input  logic               longp_excp_o_ready,
  output logic [7:0]         wb_stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WB    = 2'd1,
    ST_EXC   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [XLEN-1:0]    wdat_reg;
  logic [RFIDX_W-1:0] rdidx_reg;
  logic [7:0]         stall_cnt_reg;

  logic lsu_match, mdv_match, sel_lsu, sel_mdv, any_match;
  logic consume, can_acc, accept, acc_err, load_wb;

  // Only the oldest outstanding entry may write back; LSU has priority if
  // both claim the same tag (should never happen in a legal system).
  assign lsu_match = lsu_wbck_i_valid & ~oitf_empty & (lsu_wbck_i_itag == oitf_ret_ptr);
  assign mdv_match = mdv_wbck_i_valid & ~oitf_empty & (mdv_wbck_i_itag == oitf_ret_ptr);
  assign sel_lsu   = lsu_match;
  assign sel_mdv   = mdv_match & ~lsu_match;
  assign any_match = lsu_match | mdv_match;

  // Held entry leaving the stage this cycle frees it for a pass-through refill.
  assign consume = ((state_reg == ST_WB)  & longp_wbck_o_ready) |
                   ((state_reg == ST_EXC) & longp_excp_o_ready);
  assign can_acc = (state_reg == ST_EMPTY) | consume;

  // Gate with reset so an entry offered during reset is never retired.
  assign accept  = any_match & can_acc & rst_n;
  assign acc_err = sel_lsu & lsu_wbck_i_err;
  assign load_wb = accept & ~acc_err & oitf_ret_rdwen;

  assign lsu_wbck_i_ready = accept & sel_lsu;
  assign mdv_wbck_i_ready = accept & sel_mdv;
  assign oitf_ret_ena     = accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      if (acc_err) begin
        state_next = ST_EXC;
      end else if (oitf_ret_rdwen) begin
        state_next = ST_WB;
      end else begin
        state_next = ST_EMPTY;
      end
    end else if (consume) begin
      state_next = ST_EMPTY;
    end
  end

  // Data is only written for a real write-back; exceptions and retire-only
  // results leave the previous data untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdat_reg  <= '0;
      rdidx_reg <= '0;
    end else if (load_wb) begin
      wdat_reg  <= sel_lsu ? lsu_wbck_i_wdat : mdv_wbck_i_wdat;
      rdidx_reg <= oitf_ret_rdidx;
    end
  end

  assign longp_wbck_o_valid = (state_reg == ST_WB);
  assign longp_excp_o_valid = (state_reg == ST_EXC);
  assign longp_wbck_o_wdat  = wdat_reg;
  assign longp_wbck_o_rdidx = rdidx_reg;

  logic stall;
  assign stall = (longp_wbck_o_valid & ~longp_wbck_o_ready) |
                 (longp_excp_o_valid & ~longp_excp_o_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= 8'd0;
    end else if (stall && (stall_cnt_reg != 8'hFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 8'd1;
    end
  end

  assign wb_stall_cnt = stall_cnt_reg;

endmodule
